// File: rtl/reg_seq.sv
// ============================================================================
// Module   : reg_seq
// Brief    : Register-transfer sequencer producing bus output enables and a
//            single glitch-free write strobe (DRIVE -> WRITE -> HOLD).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_seq #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned HOLD   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] src_a,
    input  logic [1:0] src_b,
    input  logic [1:0] dst,
    input  logic       en_a,
    input  logic       en_b,
    input  logic       we,
    output logic [3:0] n_oe_a,
    output logic [3:0] n_oe_b,
    output logic [3:0] w_clk,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WRITE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [3:0] C_HOLD_LOAD   = 4'(HOLD - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_src_a, r_src_b, r_dst;
    logic       r_en_a, r_en_b, r_we;

    logic       w_accept;
    logic [1:0] w_sa, w_sb;
    logic       w_ea, w_eb;
    logic [3:0] w_oe_a_nxt, w_oe_b_nxt, w_clk_nxt;
    logic       w_done_nxt;

    assign w_accept = (r_state == ST_IDLE) && start;

    // On the accepting edge the latches are not loaded yet, so use live inputs.
    assign w_sa = w_accept ? src_a : r_src_a;
    assign w_sb = w_accept ? src_b : r_src_b;
    assign w_ea = w_accept ? en_a  : r_en_a;
    assign w_eb = w_accept ? en_b  : r_en_b;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_DRIVE;
                    w_cnt_nxt   = C_SETTLE_LOAD;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == 4'd0) begin
                    if (r_we) begin
                        w_state_nxt = ST_WRITE;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = C_HOLD_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = C_HOLD_LOAD;
            end
            ST_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase

        // Outputs are decoded from the next state and registered, so every
        // output pin is a flop and the strobe cannot glitch.
        w_oe_a_nxt = 4'hf;
        w_oe_b_nxt = 4'hf;
        w_clk_nxt  = 4'h0;
        if (w_state_nxt != ST_IDLE) begin
            if (w_ea) w_oe_a_nxt[w_sa] = 1'b0;
            if (w_eb) w_oe_b_nxt[w_sb] = 1'b0;
        end
        if (w_state_nxt == ST_WRITE) w_clk_nxt[r_dst] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            n_oe_a  <= 4'hf;
            n_oe_b  <= 4'hf;
            w_clk   <= 4'h0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            n_oe_a  <= w_oe_a_nxt;
            n_oe_b  <= w_oe_b_nxt;
            w_clk   <= w_clk_nxt;
            busy    <= (w_state_nxt != ST_IDLE);
            done    <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_a <= 2'd0;
            r_src_b <= 2'd0;
            r_dst   <= 2'd0;
            r_en_a  <= 1'b0;
            r_en_b  <= 1'b0;
            r_we    <= 1'b0;
        end else if (w_accept) begin
            r_src_a <= src_a;
            r_src_b <= src_b;
            r_dst   <= dst;
            r_en_a  <= en_a;
            r_en_b  <= en_b;
            r_we    <= we;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_seq.sv
// ============================================================================
// Module   : tb_reg_seq
// Brief    : Directed, table-driven self-checking bench for reg_seq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_seq;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned HOLD   = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] src_a = 2'd0, src_b = 2'd0, dst = 2'd0;
    logic       en_a = 1'b0, en_b = 1'b0, we = 1'b0;
    logic [3:0] n_oe_a, n_oe_b, w_clk;
    logic       busy, done;

    int n_pass  = 0;
    int n_total = 0;

    reg_seq #(.SETTLE(SETTLE), .HOLD(HOLD)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .src_a  (src_a),
        .src_b  (src_b),
        .dst    (dst),
        .en_a   (en_a),
        .en_b   (en_b),
        .we     (we),
        .n_oe_a (n_oe_a),
        .n_oe_b (n_oe_b),
        .w_clk  (w_clk),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] d;
        logic       ea;
        logic       eb;
        logic       wr;
        logic [3:0] exp_oe_a;
        logic [3:0] exp_oe_b;
        logic [3:0] exp_wclk;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string nm, input logic exp_done);
        chk({nm, "_oe_a"}, n_oe_a, 4'hf);
        chk({nm, "_oe_b"}, n_oe_b, 4'hf);
        chk({nm, "_wclk"}, w_clk, 4'h0);
        chk({nm, "_busy"}, {3'b0, busy}, 4'h0);
        chk({nm, "_done"}, {3'b0, done}, {3'b0, exp_done});
    endtask

    // Launch one sequence from IDLE, scramble inputs and poke start while busy,
    // then check every cycle through done and the idle cycle after it.
    task automatic run_vec(input vec_t v);
        int act_len;
        act_len = int'(SETTLE + HOLD) + (v.wr ? 1 : 0);
        src_a = v.sa; src_b = v.sb; dst = v.d;
        en_a = v.ea;  en_b = v.eb;  we = v.wr;
        start = 1'b1;
        tick();
        src_a = ~v.sa; src_b = ~v.sb; dst = ~v.d;
        en_a = ~v.ea;  en_b = ~v.eb;  we = ~v.wr;
        for (int k = 1; k <= act_len; k++) begin
            start = (k == 2);
            chk("seq_oe_a", n_oe_a, v.exp_oe_a);
            chk("seq_oe_b", n_oe_b, v.exp_oe_b);
            chk("seq_wclk", w_clk, (v.wr && k == int'(SETTLE) + 1) ? v.exp_wclk : 4'h0);
            chk("seq_busy", {3'b0, busy}, 4'h1);
            chk("seq_done", {3'b0, done}, 4'h0);
            tick();
        end
        start = 1'b0;
        chk_idle("seq_donecyc", 1'b1);
        tick();
        chk_idle("seq_after", 1'b0);
    endtask

    initial begin
        //          sa    sb    d     ea    eb    we    oe_a   oe_b   wclk
        vecs[0] = '{2'd1, 2'd2, 2'd3, 1'b1, 1'b1, 1'b1, 4'hd, 4'hb, 4'h8};
        vecs[1] = '{2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 4'he, 4'hf, 4'h0};
        vecs[2] = '{2'd2, 2'd2, 2'd2, 1'b1, 1'b1, 1'b1, 4'hb, 4'hb, 4'h4};
        vecs[3] = '{2'd3, 2'd0, 2'd1, 1'b0, 1'b1, 1'b1, 4'hf, 4'he, 4'h2};
        vecs[4] = '{2'd1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 4'hf, 4'hf, 4'h0};
        vecs[5] = '{2'd0, 2'd3, 2'd0, 1'b1, 1'b1, 1'b1, 4'he, 4'h7, 4'h1};

        // Reset held: start toggles must have no effect.
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            tick();
            chk_idle("reset", 1'b0);
        end
        start = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Start held high: one all-f done cycle separates back-to-back runs.
        src_a = 2'd1; src_b = 2'd2; dst = 2'd3; en_a = 1'b1; en_b = 1'b1; we = 1'b1;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) begin
            if (k == 5 || k == 10) begin
                chk_idle("b2b_gap", 1'b1);
            end else begin
                chk("b2b_oe_a", n_oe_a, 4'hd);
                chk("b2b_wclk", w_clk, (k == 3 || k == 8) ? 4'h8 : 4'h0);
                chk("b2b_busy", {3'b0, busy}, 4'h1);
            end
            if (k == 10) start = 1'b0;
            tick();
        end
        chk_idle("b2b_end", 1'b0);

        // Reset pulsed asynchronously during WRITE with dst=0.
        src_a = 2'd3; src_b = 2'd1; dst = 2'd0; we = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rstw_pre_wclk", w_clk, 4'h1);
        #2 rst = 1'b1;
        #1;
        chk_idle("rstw_now", 1'b0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_idle("rstw_nodone", 1'b0);
            tick();
        end
        run_vec(vecs[5]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
